sprite_anim_renderer: RTL and testbench
=======================================

Name: sprite_anim_renderer

Overview:
- Pipelined sprite pixel generator for the VGA path. It maps the current raster position onto one frame of a multi-frame sprite sheet held in an external synchronous ROM.
- Advances the animation frame on a vsync-rate tick.
- Masks transparent pixels and drives registered RGB plus an opaque flag, so the downstream compositor can layer characters over background and stage.

Parameters:
- SPR_W, 40, sprite width in pixels
- SPR_H, 60, sprite height in pixels
- NUM_FRAMES, 8, frames in the sprite sheet, stored consecutively in ROM
- FRAME_TICKS, 6, frame_start pulses per animation step (1 = advance every screen frame)
- TRANSP_IDX, 0, palette index treated as transparent
- ADDR_W, $clog2(NUM_FRAMES*SPR_W*SPR_H), ROM address width

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge
- reset  in  1  synchronous, active-high
- DrawX  in  10  current raster column
- DrawY  in  10  current raster row
- SpriteX  in  10  sprite top-left column
- SpriteY  in  10  sprite top-left row
- blank  in  1  1 = active video
- frame_start  in  1  one-cycle pulse per screen frame
- anim_en  in  1  1 = animation advances
- anim_restart  in  1  force the frame index to 0
- flip_h  in  1  mirror the sprite horizontally (see Optional Feature)
- rom_address  out  ADDR_W  address to external sprite ROM
- rom_q  in  4  ROM data, valid one cycle after rom_address is registered
- pal_index  out  4  index to external combinational palette
- pal_red, pal_green, pal_blue  in  4 each  palette output for pal_index
- red, green, blue  out  4 each  registered pixel colour
- opaque  out  1  1 = sprite pixel is drawn at this position
- frame_idx  out  $clog2(NUM_FRAMES)  current animation frame

Behaviour:
- Reset: frame_idx=0, tick counter=0, rom_address=0, pal_index=0, red/green/blue=0, opaque=0, all pipeline valid bits=0.
- Stage 0, on posedge:
  - dx=DrawX-SpriteX and dy=DrawY-SpriteY, computed as 11-bit signed values.
  - in_box = (0<=dx<SPR_W) && (0<=dy<SPR_H) && blank.
  - col = flip ? SPR_W-1-dx : dx.
  - rom_address <= frame_idx*SPR_W*SPR_H + dy*SPR_W + col when in_box, else 0.
  - v1 <= in_box.
- Stage 1: rom_q is valid. pal_index <= rom_q, and v2 <= v1 && (rom_q != TRANSP_IDX).
- Stage 2 (outputs):
  - opaque <= v2.
  - When v2=1: red/green/blue <= pal_*. When v2=0: red/green/blue <= 0.
  - pal_index drives the palette combinationally within the stage-2 cycle.
- Latency is exactly 3 vga_clk cycles from DrawX/DrawY to red/green/blue/opaque. The pipeline never stalls.
- Out-of-box and blanked pixels always produce opaque=0 and RGB=0, regardless of rom_q.
- Frame edges:
  - SpriteX near 639 or SpriteY near 479 lets the sprite clip naturally; no wrap.
  - SpriteX > DrawX gives negative dx, which is out of box.
- Animation:
  - The tick counter counts frame_start pulses only while anim_en=1.
  - On the pulse where tick == FRAME_TICKS-1: tick <= 0 and frame_idx <= (frame_idx == NUM_FRAMES-1) ? 0 : frame_idx+1.
  - frame_idx changes only on a frame_start cycle, so there is no mid-frame tearing.
  - anim_en=0 holds both the tick counter and frame_idx.
  - anim_restart=1 sets frame_idx=0 and tick=0 on the next edge. It takes priority over a simultaneous frame_start.
  - reset takes priority over everything.
- Reset asserted mid-line flushes the pipeline: opaque=0 and RGB=0 from the next edge.

Optional Feature:
- SPRITE_FLIP_EN defined: flip = flip_h. flip_h is sampled in stage 0 per pixel, so the source must hold it stable across a frame.
- SPRITE_FLIP_EN undefined: flip = 0, the flip_h port is ignored, and no subtractor is built.

Test Plan:
- Reset, then sprite at (100,50), DrawX=100, DrawY=50, ROM word 0 = 4'h3, pal returns F/8/1 -> three cycles later red=F, green=8, blue=1, opaque=1; rom_address was 0.
- DrawX=139, DrawY=109 (last in-box pixel) -> rom_address=2399 for frame 0. DrawX=140 -> opaque=0 and RGB=0 three cycles later.
- rom_q=TRANSP_IDX (0) inside the box -> opaque=0 and RGB=0 even though pal_* are nonzero.
- anim_en=1, FRAME_TICKS=6, 48 frame_start pulses -> frame_idx steps 0..7 every 6 pulses and wraps to 0. In frame 2, pixel (0,0) drives rom_address=4800.
- anim_restart and frame_start in the same cycle at frame_idx=5 -> frame_idx=0 and tick=0. anim_en=0 for 10 pulses -> frame_idx unchanged.
- SPRITE_FLIP_EN defined, flip_h=1, dx=0, dy=0 -> rom_address=39. Macro undefined, same stimulus -> rom_address=0.

Source files
------------

// File: rtl/sprite_anim_renderer_if.sv
// Raster, ROM and palette signals of the sprite renderer, bundled for the port list.
// master = raster/ROM/palette side, slave = renderer.
interface sprite_anim_renderer_if #(
    parameter int ADDR_W = 15,
    parameter int FIDX_W = 3
);
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [9:0]        SpriteX;
    logic [9:0]        SpriteY;
    logic              blank;
    logic              frame_start;
    logic              anim_en;
    logic              anim_restart;
    logic              flip_h;
    logic [ADDR_W-1:0] rom_address;
    logic [3:0]        rom_q;
    logic [3:0]        pal_index;
    logic [3:0]        pal_red;
    logic [3:0]        pal_green;
    logic [3:0]        pal_blue;
    logic [3:0]        red;
    logic [3:0]        green;
    logic [3:0]        blue;
    logic              opaque;
    logic [FIDX_W-1:0] frame_idx;

    modport master (
        output DrawX, DrawY, SpriteX, SpriteY, blank, frame_start, anim_en,
               anim_restart, flip_h, rom_q, pal_red, pal_green, pal_blue,
        input  rom_address, pal_index, red, green, blue, opaque, frame_idx
    );

    modport slave (
        input  DrawX, DrawY, SpriteX, SpriteY, blank, frame_start, anim_en,
               anim_restart, flip_h, rom_q, pal_red, pal_green, pal_blue,
        output rom_address, pal_index, red, green, blue, opaque, frame_idx
    );
endinterface

// File: rtl/sprite_anim_renderer.sv
// Three-stage sprite pixel pipeline with vsync-rate frame animation.
// Optional horizontal mirroring is compiled in when SPRITE_FLIP_EN is defined.
module sprite_anim_renderer #(
    parameter int SPR_W       = 40,
    parameter int SPR_H       = 60,
    parameter int NUM_FRAMES  = 8,
    parameter int FRAME_TICKS = 6,
    parameter int TRANSP_IDX  = 0,
    parameter int ADDR_W      = $clog2(NUM_FRAMES*SPR_W*SPR_H),
    parameter int FIDX_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic            vga_clk,
    input  logic            reset,
    sprite_anim_renderer_if.slave bus
);
    localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    logic [FIDX_W-1:0] frame_q, frame_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              v1_q, v1_d;
    logic [3:0]        pal_idx_q, pal_idx_d;
    logic              v2_q, v2_d;
    logic              opaque_q, opaque_d;
    logic [3:0]        red_q, red_d;
    logic [3:0]        green_q, green_d;
    logic [3:0]        blue_q, blue_d;

    logic signed [10:0] dx, dy;
    logic               in_box;
    logic [9:0]         col;

    // Zero-extended subtraction keeps the sign, so a sprite right of the beam is out of box.
    assign dx = $signed({1'b0, bus.DrawX}) - $signed({1'b0, bus.SpriteX});
    assign dy = $signed({1'b0, bus.DrawY}) - $signed({1'b0, bus.SpriteY});

    assign in_box = !dx[10] && (dx[9:0] < 10'(SPR_W)) &&
                    !dy[10] && (dy[9:0] < 10'(SPR_H)) && bus.blank;

`ifdef SPRITE_FLIP_EN
    assign col = bus.flip_h ? (10'(SPR_W - 1) - dx[9:0]) : dx[9:0];
`else
    assign col = dx[9:0];
    logic unused_flip;
    assign unused_flip = bus.flip_h;
`endif

    always_comb begin
        addr_d = '0;
        if (in_box) begin
            addr_d = ADDR_W'(frame_q) * ADDR_W'(SPR_W * SPR_H)
                   + ADDR_W'(dy[9:0]) * ADDR_W'(SPR_W)
                   + ADDR_W'(col);
        end
        v1_d      = in_box;
        pal_idx_d = bus.rom_q;
        v2_d      = v1_q && (bus.rom_q != 4'(TRANSP_IDX));
        opaque_d  = v2_q;
        red_d     = v2_q ? bus.pal_red   : 4'h0;
        green_d   = v2_q ? bus.pal_green : 4'h0;
        blue_d    = v2_q ? bus.pal_blue  : 4'h0;
    end

    // Frame index only moves on a frame_start cycle, so a screen never shows two frames.
    always_comb begin
        frame_d = frame_q;
        tick_d  = tick_q;
        if (bus.anim_restart) begin
            frame_d = '0;
            tick_d  = '0;
        end else if (bus.frame_start && bus.anim_en) begin
            if (tick_q == TICK_W'(FRAME_TICKS - 1)) begin
                tick_d  = '0;
                frame_d = (frame_q == FIDX_W'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            frame_q   <= '0;
            tick_q    <= '0;
            addr_q    <= '0;
            v1_q      <= 1'b0;
            pal_idx_q <= '0;
            v2_q      <= 1'b0;
            opaque_q  <= 1'b0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else begin
            frame_q   <= frame_d;
            tick_q    <= tick_d;
            addr_q    <= addr_d;
            v1_q      <= v1_d;
            pal_idx_q <= pal_idx_d;
            v2_q      <= v2_d;
            opaque_q  <= opaque_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
        end
    end

    assign bus.rom_address = addr_q;
    assign bus.pal_index   = pal_idx_q;
    assign bus.opaque      = opaque_q;
    assign bus.red         = red_q;
    assign bus.green       = green_q;
    assign bus.blue        = blue_q;
    assign bus.frame_idx   = frame_q;
endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Bench for sprite_anim_renderer: directed vector table, animation sequences, and
// randomized raster traffic checked against a pixel-level reference model.
module tb_sprite_anim_renderer;
    localparam int SPR_W = 40;
    localparam int SPR_H = 60;
    localparam int NF    = 8;
    localparam int FT    = 6;
    localparam int AW    = 15;
`ifdef SPRITE_FLIP_EN
    localparam bit FLIP = 1'b1;
`else
    localparam bit FLIP = 1'b0;
`endif

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;
    always #5 vga_clk = ~vga_clk;

    sprite_anim_renderer_if #(.ADDR_W(AW), .FIDX_W(3)) bus ();

    sprite_anim_renderer dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic       rom_force     = 1'b0;
    logic [3:0] rom_force_val = 4'h0;

    // Synthetic sprite sheet; word 0 is 3 so the first pixel is visible.
    function automatic logic [3:0] rom_fn(input int a);
        if (a == 0) return 4'h3;
        return 4'((a ^ (a >> 4) ^ (a >> 9)) & 15);
    endfunction

    function automatic logic [11:0] pal_fn(input logic [3:0] i);
        return {i ^ 4'hC, i ^ 4'hB, i ^ 4'h2};
    endfunction

    logic [11:0] pal_rgb;
    assign pal_rgb       = pal_fn(bus.pal_index);
    assign bus.pal_red   = pal_rgb[11:8];
    assign bus.pal_green = pal_rgb[7:4];
    assign bus.pal_blue  = pal_rgb[3:0];
    assign bus.rom_q     = rom_force ? rom_force_val : rom_fn(int'(bus.rom_address));

    typedef struct packed {
        logic        op;
        logic [11:0] rgb;
    } pix_t;

    pix_t hist[3];
    int   m_addr  = 0;
    int   m_frame = 0;
    int   m_tick  = 0;

    // Reference: what the screen should show for the pixel currently on the inputs.
    function automatic void model_pix(output int addr, output pix_t p);
        int dx, dy, col;
        logic [3:0] q;
        dx   = int'(bus.DrawX) - int'(bus.SpriteX);
        dy   = int'(bus.DrawY) - int'(bus.SpriteY);
        addr = 0;
        p    = '0;
        if (bus.blank && dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H) begin
            col  = (FLIP && bus.flip_h) ? (SPR_W - 1 - dx) : dx;
            addr = m_frame * SPR_W * SPR_H + dy * SPR_W + col;
            q    = rom_force ? rom_force_val : rom_fn(addr);
            if (q != 4'h0) p = '{op: 1'b1, rgb: pal_fn(q)};
        end
    endfunction

    task automatic step();
        int   a;
        pix_t p;
        model_pix(a, p);
        @(posedge vga_clk);
        if (reset) begin
            hist[0] = '0; hist[1] = '0; hist[2] = '0;
            m_addr = 0; m_frame = 0; m_tick = 0;
        end else begin
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = p;
            m_addr = a;
            if (bus.anim_restart) begin
                m_frame = 0; m_tick = 0;
            end else if (bus.frame_start && bus.anim_en) begin
                m_tick = m_tick + 1;
                if (m_tick == FT) begin
                    m_tick  = 0;
                    m_frame = (m_frame + 1) % NF;
                end
            end
        end
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string nm);
        chk({nm, ".addr"},   32'(bus.rom_address), 32'(m_addr));
        chk({nm, ".opaque"}, 32'(bus.opaque), 32'(hist[2].op));
        chk({nm, ".rgb"},    32'({bus.red, bus.green, bus.blue}), 32'(hist[2].rgb));
        chk({nm, ".frame"},  32'(bus.frame_idx), 32'(m_frame));
    endtask

    task automatic set_pix(input int x, input int y, input int sx, input int sy, input logic bl);
        bus.DrawX = 10'(x); bus.DrawY = 10'(y);
        bus.SpriteX = 10'(sx); bus.SpriteY = 10'(sy);
        bus.blank = bl;
    endtask

    task automatic pulse();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        step();
    endtask

    typedef struct {
        int          x, y, sx, sy;
        logic        bl;
        int          addr;
        logic        op;
        logic [11:0] rgb;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{100,  50, 100,  50, 1'b1,    0, 1'b1, 12'hF81};
        vt[1] = '{139, 109, 100,  50, 1'b1, 2399, 1'b1, 12'h25C};
        vt[2] = '{140, 109, 100,  50, 1'b1,    0, 1'b0, 12'h000};
        vt[3] = '{100,  50, 100,  50, 1'b0,    0, 1'b0, 12'h000};
        vt[4] = '{ 99,  50, 100,  50, 1'b1,    0, 1'b0, 12'h000};
        vt[5] = '{639, 479, 620, 470, 1'b1,  379, 1'b1, 12'h07E};
        vt[6] = '{  5,  10, 630,   0, 1'b1,    0, 1'b0, 12'h000};
        vt[7] = '{100, 110, 100,  50, 1'b1,    0, 1'b0, 12'h000};

        hist[0] = '0; hist[1] = '0; hist[2] = '0;
        set_pix(0, 0, 0, 0, 1'b0);
        bus.frame_start = 1'b0; bus.anim_en = 1'b0;
        bus.anim_restart = 1'b0; bus.flip_h = 1'b0;

        step(); step();
        chk("reset.addr",   32'(bus.rom_address), 32'd0);
        chk("reset.opaque", 32'(bus.opaque), 32'd0);
        chk("reset.rgb",    32'({bus.red, bus.green, bus.blue}), 32'd0);
        chk("reset.frame",  32'(bus.frame_idx), 32'd0);
        chk("reset.pal",    32'(bus.pal_index), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            set_pix(vt[i].x, vt[i].y, vt[i].sx, vt[i].sy, vt[i].bl);
            step();
            chk($sformatf("vec%0d.addr", i), 32'(bus.rom_address), 32'(vt[i].addr));
            step(); step();
            chk($sformatf("vec%0d.opaque", i), 32'(bus.opaque), 32'(vt[i].op));
            chk($sformatf("vec%0d.rgb", i), 32'({bus.red, bus.green, bus.blue}), 32'(vt[i].rgb));
        end

        // Transparent index inside the box while the palette is nonzero.
        rom_force = 1'b1; rom_force_val = 4'h0;
        set_pix(110, 60, 100, 50, 1'b1);
        step(); step(); step();
        chk("transp.opaque", 32'(bus.opaque), 32'd0);
        chk("transp.rgb",    32'({bus.red, bus.green, bus.blue}), 32'd0);
        rom_force = 1'b0;

        bus.flip_h = 1'b1;
        set_pix(100, 50, 100, 50, 1'b1);
        step();
        chk("flip.addr", 32'(bus.rom_address), FLIP ? 32'd39 : 32'd0);
        bus.flip_h = 1'b0;

        // Mid-line reset flushes the pipeline.
        step(); step(); step();
        chk("midrst.pre_opaque", 32'(bus.opaque), 32'd1);
        reset = 1'b1;
        step();
        chk("midrst.opaque", 32'(bus.opaque), 32'd0);
        chk("midrst.rgb",    32'({bus.red, bus.green, bus.blue}), 32'd0);
        reset = 1'b0;
        set_pix(0, 0, 100, 50, 1'b1);
        step();
        chk("midrst.post_opaque", 32'(bus.opaque), 32'd0);

        bus.anim_en = 1'b1;
        for (int i = 0; i < 48; i++) begin
            pulse();
            chk($sformatf("anim.p%0d", i), 32'(bus.frame_idx), 32'(((i + 1) / FT) % NF));
        end
        for (int i = 0; i < 12; i++) pulse();
        chk("anim.frame2", 32'(bus.frame_idx), 32'd2);
        set_pix(100, 50, 100, 50, 1'b1);
        step();
        chk("anim.frame2_addr", 32'(bus.rom_address), 32'd4800);
        for (int i = 0; i < 18; i++) pulse();
        chk("anim.frame5", 32'(bus.frame_idx), 32'd5);
        for (int i = 0; i < 2; i++) pulse();
        bus.anim_restart = 1'b1; bus.frame_start = 1'b1;
        step();
        bus.anim_restart = 1'b0; bus.frame_start = 1'b0;
        step();
        chk("restart.frame", 32'(bus.frame_idx), 32'd0);
        for (int i = 0; i < 5; i++) pulse();
        chk("restart.tick_zero", 32'(bus.frame_idx), 32'd0);
        pulse();
        chk("restart.first_step", 32'(bus.frame_idx), 32'd1);
        bus.anim_en = 1'b0;
        for (int i = 0; i < 10; i++) pulse();
        chk("hold.frame", 32'(bus.frame_idx), 32'd1);
        check_model("hold.model");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                bus.SpriteX = 10'($urandom_range(0, 639));
                bus.SpriteY = 10'($urandom_range(0, 479));
            end
            bus.DrawX = 10'(int'(bus.SpriteX) + int'($urandom_range(0, 60)) - 10);
            bus.DrawY = 10'(int'(bus.SpriteY) + int'($urandom_range(0, 80)) - 10);
            bus.blank        = ($urandom_range(0, 9) != 0);
            bus.frame_start  = ($urandom_range(0, 7) == 0);
            bus.anim_en      = ($urandom_range(0, 4) != 0);
            bus.anim_restart = ($urandom_range(0, 99) == 0);
            bus.flip_h       = 1'($urandom_range(0, 1));
            reset            = ($urandom_range(0, 299) == 0);
            step();
            check_model($sformatf("rand%0d", i));
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
